// File: rtl/pc_fetch_unit.sv
// pc_fetch_unit: program-counter register and instruction-fetch sequencer.
// Forms sequential, branch, jump and JR targets and runs a req/ack fetch
// handshake with instruction memory. It presents Instr/PC/PCPlus4 to decode.
module pc_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        Clk,
  input  logic        Rst_n,
  input  logic        Jump,
  input  logic [25:0] JumpIdx,
  input  logic        Branch,
  input  logic [15:0] BranchOff,
  input  logic        JumpReg,
  input  logic [31:0] RegTarget,
  input  logic        Stall,
  input  logic        ImemAck,
  input  logic [31:0] ImemData,
  output logic        ImemReq,
  output logic [31:0] ImemAddr,
  output logic [31:0] Instr,
  output logic        InstrValid,
  output logic [31:0] PC,
  output logic [31:0] PCPlus4,
  output logic        AddrErr
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_HOLD = 2'd2
  } state_t;

  // RESET_PC is expected to be word aligned; the low bits are forced
  // clear so that a bad override still yields an aligned fetch address.
  localparam logic [31:0] RESET_PC_ALIGNED = {RESET_PC[31:2], 2'b00};

  state_t      state_q;
  state_t      state_d;
  logic [31:0] pc_q;
  logic [31:0] pc_next;
  logic [31:0] pc_plus4;
  logic [31:0] branch_tgt;
  logic [31:0] jump_tgt;
  logic [31:0] jr_tgt;
  logic [31:0] branch_disp;
  logic [31:0] instr_q;
  logic        instr_valid_q;
  logic        addr_err_q;
  logic        pc_load;
  logic        instr_load;
  logic        addr_err_d;

  // Candidate targets; all adds wrap modulo 2^32 without any flag.
  always_comb begin
    pc_plus4    = pc_q + 32'd4;
    branch_disp = {{14{BranchOff[15]}}, BranchOff, 2'b00};
    branch_tgt  = pc_plus4 + branch_disp;
    jump_tgt    = {pc_plus4[31:28], JumpIdx, 2'b00};
    jr_tgt      = {RegTarget[31:2], 2'b00};
  end

  // Next-PC selection: JumpReg over Jump over Branch over sequential.
  always_comb begin
    pc_next = pc_plus4;
    if (JumpReg) begin
      pc_next = jr_tgt;
    end else if (Jump) begin
      pc_next = jump_tgt;
    end else if (Branch) begin
      pc_next = branch_tgt;
    end
  end

  // Fetch sequencer next-state and datapath load enables.
  always_comb begin
    state_d    = state_q;
    pc_load    = 1'b0;
    instr_load = 1'b0;
    addr_err_d = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        state_d = S_REQ;
      end
      S_REQ: begin
        if (ImemAck) begin
          instr_load = 1'b1;
          state_d    = S_HOLD;
        end
      end
      S_HOLD: begin
        // Redirect inputs matter only on the advancing cycle; a stall
        // freezes everything including the redirect decision.
        if (!Stall) begin
          pc_load    = 1'b1;
          addr_err_d = JumpReg & (RegTarget[1:0] != 2'b00);
          state_d    = S_REQ;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Sequencer state register.
  always_ff @(posedge Clk) begin
    if (!Rst_n) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // PC, fetched instruction, valid flag and misaligned-JR pulse.
  always_ff @(posedge Clk) begin
    if (!Rst_n) begin
      pc_q          <= RESET_PC_ALIGNED;
      instr_q       <= '0;
      instr_valid_q <= 1'b0;
      addr_err_q    <= 1'b0;
    end else begin
      addr_err_q <= addr_err_d;
      if (pc_load) begin
        pc_q          <= pc_next;
        instr_valid_q <= 1'b0;
      end
      if (instr_load) begin
        instr_q       <= ImemData;
        instr_valid_q <= 1'b1;
      end
    end
  end

  // Output mapping.
  always_comb begin
    ImemReq    = (state_q == S_REQ);
    ImemAddr   = pc_q;
    Instr      = instr_q;
    InstrValid = instr_valid_q;
    PC         = pc_q;
    PCPlus4    = pc_plus4;
    AddrErr    = addr_err_q;
  end

endmodule
